// File: rtl/parity_pkg.sv
// parity_pkg: shared encodings for the serial parity unit.
package parity_pkg;

  // Frame FSM: S_PAR is only entered in check mode, to take the received parity bit.
  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

  // Operating mode, latched at the first accepted bit of each frame.
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// parity_accum: XOR accumulator with a saturating accepted-bit counter.
module parity_accum #(
  parameter  int FRAME_BITS = 8,
  localparam int CNT_W      = $clog2(FRAME_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr,
  output logic             acc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS);

  // Fold each accepted bit into the parity and count it; clr restarts the frame.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (rst || clr) begin
      acc <= 1'b0;
      cnt <= '0;
    end else if (en) begin
      acc <= acc ^ x;
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_parity_unit.sv
// serial_parity_unit: framed parity generator (mode 0) or checker (mode 1).
module serial_parity_unit
  import parity_pkg::*;
#(
  parameter  int FRAME_BITS = 8,
  parameter  bit ODD        = 1'b0,
  localparam int CNT_W      = $clog2(FRAME_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             clr,
  input  logic             x_valid,
  input  logic             x,
  output logic             z,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done,
  output logic             par_out,
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_BITS - 1);

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   acc;
  logic   accept;
  logic   at_start;
  logic   cur_mode;
  logic   gen_done;
  logic   chk_done;
  logic   acc_clr;

  parity_accum #(.FRAME_BITS(FRAME_BITS)) u_accum (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .x   (x),
    .clr (acc_clr),
    .acc (acc),
    .cnt (bit_cnt)
  );

  // Next-state and frame-completion decode; mode is taken live on the frame's first bit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d  = state_q;
    mode_d   = mode_q;
    gen_done = 1'b0;
    chk_done = 1'b0;
    accept   = x_valid && !clr;
    at_start = (state_q == S_DATA) && (bit_cnt == '0);
    cur_mode = at_start ? mode : mode_q;
    if (accept) begin
      if (at_start) mode_d = mode;
      unique case (state_q)
        S_DATA: begin
          if (bit_cnt == LAST_DATA) begin
            if (cur_mode == MODE_GEN) gen_done = 1'b1;
            else                      state_d  = S_PAR;
          end
        end
        S_PAR: begin
          chk_done = 1'b1;
          state_d  = S_DATA;
        end
      endcase
    end
    if (clr) state_d = S_DATA;
    acc_clr = clr || gen_done || chk_done;
  end

  // State register and frame-start mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DATA;
      mode_q  <= MODE_GEN;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Output registers: running parity, completion pulse and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      z          <= ODD;
      frame_done <= 1'b0;
      par_out    <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= gen_done || chk_done;
      if (gen_done) par_out <= acc ^ x ^ ODD;
      if (chk_done) err     <= acc ^ x ^ ODD;
      if (acc_clr)     z <= ODD;
      else if (accept) z <= acc ^ x ^ ODD;
    end
  end

endmodule

// File: tb/tb_serial_parity_unit.sv
// tb_serial_parity_unit: scoreboard bench driving an even and an odd instance in parallel.
module tb_serial_parity_unit;

  localparam int FB = 8;
  localparam int CW = $clog2(FB + 1);

  typedef struct packed {
    logic is_chk;
    logic val;
  } exp_t;

  logic clk = 1'b0;
  logic rst, mode, clr, x_valid, x;
  logic z0, fd0, par0, err0;
  logic z1, fd1, par1, err1;
  logic [CW-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state, kept independently of the DUT.
  logic m_acc, m_chk, m_mode, exp_fd;
  int   m_cnt;
  logic exp_par[2];
  logic exp_err[2];
  exp_t sb0[$];
  exp_t sb1[$];

  logic par_seen[$];
  logic err_seen[$];
  logic z_seen[$];
  int   fd_cyc[$];

  serial_parity_unit #(.FRAME_BITS(FB), .ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .clr(clr), .x_valid(x_valid), .x(x),
    .z(z0), .bit_cnt(cnt0), .frame_done(fd0), .par_out(par0), .err(err0)
  );

  serial_parity_unit #(.FRAME_BITS(FB), .ODD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .clr(clr), .x_valid(x_valid), .x(x),
    .z(z1), .bit_cnt(cnt1), .frame_done(fd1), .par_out(par1), .err(err1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic compare(input int k, input logic zv, input logic [CW-1:0] c,
                         input logic fd, input logic p, input logic e);
    logic odd;
    exp_t ex;
    int   depth;
    odd = (k == 1);
    check($sformatf("z[%0d]", k), zv, m_acc ^ odd);
    check($sformatf("bit_cnt[%0d]", k), c, m_cnt);
    check($sformatf("frame_done[%0d]", k), fd, exp_fd);
    if (fd) begin
      depth = (k == 0) ? sb0.size() : sb1.size();
      check($sformatf("sb_pending[%0d]", k), depth > 0, 1);
      if (depth > 0) begin
        if (k == 0) ex = sb0.pop_front();
        else        ex = sb1.pop_front();
        if (ex.is_chk) exp_err[k] = ex.val;
        else           exp_par[k] = ex.val;
      end
      if (k == 0) begin
        par_seen.push_back(p);
        err_seen.push_back(e);
        fd_cyc.push_back(cyc);
      end
    end
    check($sformatf("par_out[%0d]", k), p, exp_par[k]);
    check($sformatf("err[%0d]", k), e, exp_err[k]);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare both DUTs #1 later.
  task automatic cycle(input logic v, input logic b, input logic c, input logic r);
    x_valid = v;
    x       = b;
    clr     = c;
    rst     = r;
    @(posedge clk);
    exp_fd = 1'b0;
    if (r) begin
      m_acc = 1'b0; m_cnt = 0; m_chk = 1'b0; m_mode = 1'b0;
      sb0.delete(); sb1.delete();
      exp_par = '{1'b0, 1'b0};
      exp_err = '{1'b0, 1'b0};
    end else if (c) begin
      m_acc = 1'b0; m_cnt = 0; m_chk = 1'b0;
    end else if (v) begin
      if (!m_chk && m_cnt == 0) m_mode = mode;
      if (m_chk) begin
        sb0.push_back('{1'b1, m_acc ^ b});
        sb1.push_back('{1'b1, ~(m_acc ^ b)});
        m_acc = 1'b0; m_cnt = 0; m_chk = 1'b0; exp_fd = 1'b1;
      end else begin
        m_acc = m_acc ^ b;
        m_cnt++;
        if (m_cnt == FB) begin
          if (!m_mode) begin
            sb0.push_back('{1'b0, m_acc});
            sb1.push_back('{1'b0, ~m_acc});
            m_acc = 1'b0; m_cnt = 0; exp_fd = 1'b1;
          end else begin
            m_chk = 1'b1;
          end
        end
      end
    end
    #1;
    cyc++;
    compare(0, z0, cnt0, fd0, par0, err0);
    compare(1, z1, cnt1, fd1, par1, err1);
  endtask

  // Eight data bits, first bit in the MSB, with up to max_gap idle cycles before each.
  task automatic send_frame(input logic [7:0] bits, input int max_gap);
    for (int i = 7; i >= 0; i--) begin
      repeat ($urandom_range(0, max_gap)) cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
      cycle(1'b1, bits[i], 1'b0, 1'b0);
      z_seen.push_back(z0);
    end
  endtask

  task automatic clear_seen();
    par_seen.delete(); err_seen.delete(); z_seen.delete(); fd_cyc.delete();
  endtask

  initial begin
    logic [7:0] zexp;
    mode = 1'b0; clr = 1'b0; x_valid = 1'b0; x = 1'b0; rst = 1'b1;

    // Reset state, including z = ODD on the odd instance.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_z_even", z0, 0);
    check("rst_z_odd", z1, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Generate: running z sequence and frame parity.
    clear_seen();
    zexp = 8'b11011100;
    send_frame(8'b10110010, 0);
    for (int i = 0; i < 8; i++) check($sformatf("t1_z%0d", i), z_seen[i], zexp[7-i]);
    check("t1_frames", par_seen.size(), 1);
    if (par_seen.size() == 1) check("t1_par", par_seen[0], 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back generate frames, then the same frames with random gaps.
    clear_seen();
    send_frame(8'b10110001, 0);
    send_frame(8'b10110000, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_frames", par_seen.size(), 2);
    if (par_seen.size() == 2) begin
      check("t2_par_a", par_seen[0], 0);
      check("t2_par_b", par_seen[1], 1);
      check("t2_spacing", fd_cyc[1] - fd_cyc[0], 8);
    end
    clear_seen();
    send_frame(8'b10110001, 3);
    send_frame(8'b10110000, 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2g_frames", par_seen.size(), 2);
    if (par_seen.size() == 2) begin
      check("t2g_par_a", par_seen[0], 0);
      check("t2g_par_b", par_seen[1], 1);
    end

    // Check mode: correct then wrong received parity.
    clear_seen();
    mode = 1'b1;
    send_frame(8'b10100001, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'b10100001, 2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_frames", err_seen.size(), 2);
    if (err_seen.size() == 2) begin
      check("t3_err_ok", err_seen[0], 0);
      check("t3_err_bad", err_seen[1], 1);
    end

    // Odd instance, all-zero data in generate mode.
    mode = 1'b0;
    send_frame(8'b00000000, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_par_odd", par1, 1);

    // clr after three bits, together with x_valid; the next eight bits form a full frame.
    clear_seen();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_cnt_clr", cnt0, 0);
    check("t5_no_done", fd0, 0);
    send_frame(8'b11100000, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_frames", par_seen.size(), 1);
    if (par_seen.size() == 1) check("t5_par", par_seen[0], 1);

    // rst mid-frame in check mode after five bits (err currently held at 1).
    mode = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_err_rst", err0, 0);
    check("t6_cnt_rst", cnt0, 0);
    check("t6_z_odd_rst", z1, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Mode toggled mid-frame: frame keeps the mode seen on its first bit.
    clear_seen();
    mode = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    mode = 1'b0;
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t7_waits_parity", fd0, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("t7_chk_frames", err_seen.size(), 1);
    if (err_seen.size() == 1) check("t7_err", err_seen[0], 0);
    clear_seen();
    mode = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    mode = 1'b1;
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t7_gen_frames", par_seen.size(), 1);
    if (par_seen.size() == 1) check("t7_par", par_seen[0], 1);

    // Random traffic: gaps, live mode changes and occasional clr.
    for (int i = 0; i < 400; i++) begin
      mode = 1'($urandom);
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 24) == 0, 1'b0);
    end

    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("sb_drain", sb0.size() + sb1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
